scr1_tcm_dmem_arb: RTL and testbench

Two-master arbiter sharing the single TCM data port between the core data interface (master 0) and a system-side master such as DMA or debug (master 1). Sits directly in front of the TCM dmem port, carries one outstanding transaction at a time, and routes each response to the master that issued it. Grants are round-robin by default, with an optional fixed-priority mode. Supports back-to-back transfers at one per cycle when the TCM answers in one cycle.

---
 rtl/scr1_tcm_dmem_arb.sv | 161 ++++++++++++++++
 tb/tb_scr1_tcm_dmem_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_dmem_arb.sv
// Two-master arbiter in front of the TCM data port.
// Master 0 is the core data interface, master 1 is a system-side master.
// One transaction is outstanding at a time. Each response is routed back to
// the master that issued the request.

package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

module scr1_tcm_dmem_arb
  import scr1_memif_pkg::*;
#(
  parameter bit ARB_FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // master 0 (core data)
  input  logic                 m0_req,
  input  type_scr1_mem_cmd_e   m0_cmd,
  input  type_scr1_mem_width_e m0_width,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  output logic                 m0_req_ack,
  output logic [31:0]          m0_rdata,
  output type_scr1_mem_resp_e  m0_resp,
  // master 1 (system side)
  input  logic                 m1_req,
  input  type_scr1_mem_cmd_e   m1_cmd,
  input  type_scr1_mem_width_e m1_width,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  output logic                 m1_req_ack,
  output logic [31:0]          m1_rdata,
  output type_scr1_mem_resp_e  m1_resp,
  // TCM data port
  output logic                 tcm_req,
  output type_scr1_mem_cmd_e   tcm_cmd,
  output type_scr1_mem_width_e tcm_width,
  output logic [31:0]          tcm_addr,
  output logic [31:0]          tcm_wdata,
  input  logic                 tcm_req_ack,
  input  logic [31:0]          tcm_rdata,
  input  type_scr1_mem_resp_e  tcm_resp
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_WAIT0 = 2'b01,
    ARB_WAIT1 = 2'b10
  } arb_state_e;

  arb_state_e state_r;
  logic       prio_r;        // master that wins the next tie in round-robin mode

  logic       resp_done_s;   // outstanding transfer completes this cycle
  logic       grant_allow_s; // port is free, or frees up this cycle
  logic       sel_s;         // selected master index
  logic       tcm_req_s;
  logic       accept_s;

  // Pick the winning master among the current-cycle requests.
  always_comb begin
    resp_done_s   = (tcm_resp != SCR1_MEM_RESP_NOTRDY);
    grant_allow_s = (state_r == ARB_IDLE) | resp_done_s;
    if (m0_req & m1_req) begin
      if (ARB_FIXED_PRIO) begin
        sel_s = 1'b0;
      end else begin
        sel_s = prio_r;
      end
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    tcm_req_s = grant_allow_s & (m0_req | m1_req);
    accept_s  = tcm_req_s & tcm_req_ack;
  end

  // Forward the selected master's request fields; zero when nothing is granted.
  always_comb begin
    tcm_req = tcm_req_s;
    if (tcm_req_s) begin
      if (sel_s) begin
        tcm_cmd   = m1_cmd;
        tcm_width = m1_width;
        tcm_addr  = m1_addr;
        tcm_wdata = m1_wdata;
      end else begin
        tcm_cmd   = m0_cmd;
        tcm_width = m0_width;
        tcm_addr  = m0_addr;
        tcm_wdata = m0_wdata;
      end
    end else begin
      tcm_cmd   = SCR1_MEM_CMD_RD;
      tcm_width = SCR1_MEM_WIDTH_BYTE;
      tcm_addr  = 32'h0000_0000;
      tcm_wdata = 32'h0000_0000;
    end
    m0_req_ack = tcm_req_s & ~sel_s & tcm_req_ack;
    m1_req_ack = tcm_req_s &  sel_s & tcm_req_ack;
  end

  // Route the TCM response to the owner of the outstanding transfer only.
  always_comb begin
    m0_resp  = SCR1_MEM_RESP_NOTRDY;
    m0_rdata = 32'h0000_0000;
    m1_resp  = SCR1_MEM_RESP_NOTRDY;
    m1_rdata = 32'h0000_0000;
    case (state_r)
      ARB_WAIT0: begin
        m0_resp  = tcm_resp;
        m0_rdata = tcm_rdata;
      end
      ARB_WAIT1: begin
        m1_resp  = tcm_resp;
        m1_rdata = tcm_rdata;
      end
      default: begin
        m0_resp  = SCR1_MEM_RESP_NOTRDY;
        m1_resp  = SCR1_MEM_RESP_NOTRDY;
      end
    endcase
  end

  // Track transfer ownership and rotate the tie-break pointer on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      prio_r  <= 1'b0;
    end else if (accept_s) begin
      state_r <= sel_s ? ARB_WAIT1 : ARB_WAIT0;
      prio_r  <= ~sel_s;
    end else if ((state_r != ARB_IDLE) && resp_done_s) begin
      state_r <= ARB_IDLE;
      prio_r  <= prio_r;
    end else begin
      state_r <= state_r;
      prio_r  <= prio_r;
    end
  end

endmodule : scr1_tcm_dmem_arb

// File: tb/tb_scr1_tcm_dmem_arb.sv
// Bench for scr1_tcm_dmem_arb: a round-robin and a fixed-priority instance
// share one stimulus stream and are compared against a transaction-level model.

module tb_scr1_tcm_dmem_arb;
  import scr1_memif_pkg::*;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;

  logic                 req   [2];
  type_scr1_mem_cmd_e   cmd   [2];
  type_scr1_mem_width_e width [2];
  logic [31:0]          addr  [2];
  logic [31:0]          wdata [2];
  logic                 tcm_ack;
  logic [31:0]          tcm_rdata;
  type_scr1_mem_resp_e  tcm_resp;

  // outputs indexed [instance][master]; instance 0 round-robin, 1 fixed priority
  logic                 ack_o    [2][2];
  logic [31:0]          rdata_o  [2][2];
  type_scr1_mem_resp_e  resp_o   [2][2];
  logic                 treq_o   [2];
  type_scr1_mem_cmd_e   tcmd_o   [2];
  type_scr1_mem_width_e twidth_o [2];
  logic [31:0]          taddr_o  [2];
  logic [31:0]          twdata_o [2];

  int checks   = 0;
  int failures = 0;

  // reference model: owner of the outstanding transfer (-1 none) and tie pointer
  int own [2];
  int ptr [2];
  int grants [2][$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    scr1_tcm_dmem_arb #(.ARB_FIXED_PRIO(k == 1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_req      (req[0]),
      .m0_cmd      (cmd[0]),
      .m0_width    (width[0]),
      .m0_addr     (addr[0]),
      .m0_wdata    (wdata[0]),
      .m0_req_ack  (ack_o[k][0]),
      .m0_rdata    (rdata_o[k][0]),
      .m0_resp     (resp_o[k][0]),
      .m1_req      (req[1]),
      .m1_cmd      (cmd[1]),
      .m1_width    (width[1]),
      .m1_addr     (addr[1]),
      .m1_wdata    (wdata[1]),
      .m1_req_ack  (ack_o[k][1]),
      .m1_rdata    (rdata_o[k][1]),
      .m1_resp     (resp_o[k][1]),
      .tcm_req     (treq_o[k]),
      .tcm_cmd     (tcmd_o[k]),
      .tcm_width   (twidth_o[k]),
      .tcm_addr    (taddr_o[k]),
      .tcm_wdata   (twdata_o[k]),
      .tcm_req_ack (tcm_ack),
      .tcm_rdata   (tcm_rdata),
      .tcm_resp    (tcm_resp)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m]   = 1'b0;
      cmd[m]   = SCR1_MEM_CMD_RD;
      width[m] = SCR1_MEM_WIDTH_WORD;
      addr[m]  = 32'h0;
      wdata[m] = 32'h0;
    end
    tcm_ack   = 1'b0;
    tcm_rdata = 32'h0;
    tcm_resp  = SCR1_MEM_RESP_NOTRDY;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  // Called just after a falling edge with the inputs already applied.
  task automatic cycle();
    int  win [2];
    bit  acc [2];
    bit  allow, etreq;
    int  wi;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        own[k] = -1;
        ptr[k] = 0;
      end
      allow = (own[k] < 0) || (tcm_resp != SCR1_MEM_RESP_NOTRDY);
      if (req[0] && req[1]) win[k] = (k == 1) ? 0 : ptr[k];
      else if (req[0])      win[k] = 0;
      else if (req[1])      win[k] = 1;
      else                  win[k] = -1;
      etreq  = allow && (win[k] >= 0);
      acc[k] = etreq && tcm_ack;
      wi     = (win[k] < 0) ? 0 : win[k];
      check_eq($sformatf("tcm_req[%0d]", k), 32'(treq_o[k]), 32'(etreq));
      check_eq($sformatf("tcm_cmd[%0d]", k), 32'(tcmd_o[k]), etreq ? 32'(cmd[wi]) : 32'h0);
      check_eq($sformatf("tcm_width[%0d]", k), 32'(twidth_o[k]), etreq ? 32'(width[wi]) : 32'h0);
      check_eq($sformatf("tcm_addr[%0d]", k), taddr_o[k], etreq ? addr[wi] : 32'h0);
      check_eq($sformatf("tcm_wdata[%0d]", k), twdata_o[k], etreq ? wdata[wi] : 32'h0);
      for (int m = 0; m < 2; m++) begin
        check_eq($sformatf("req_ack[%0d][%0d]", k, m), 32'(ack_o[k][m]),
                 32'(etreq && (win[k] == m) && tcm_ack));
        check_eq($sformatf("resp[%0d][%0d]", k, m), 32'(resp_o[k][m]),
                 (own[k] == m) ? 32'(tcm_resp) : 32'(SCR1_MEM_RESP_NOTRDY));
        check_eq($sformatf("rdata[%0d][%0d]", k, m), rdata_o[k][m],
                 (own[k] == m) ? tcm_rdata : 32'h0);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        own[k] = -1;
        ptr[k] = 0;
      end else if (acc[k]) begin
        own[k] = win[k];
        ptr[k] = 1 - win[k];
        grants[k].push_back(win[k]);
      end else if ((own[k] >= 0) && (tcm_resp != SCR1_MEM_RESP_NOTRDY)) begin
        own[k] = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    grants[0].delete();
    grants[1].delete();
  endtask

  initial begin
    int r;
    idle_inputs();
    own[0] = -1; own[1] = -1; ptr[0] = 0; ptr[1] = 0;
    @(negedge clk);

    // reset state, with a stray TCM response that must not leak out
    cycle();
    tcm_resp  = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata = 32'hDEAD_BEEF;
    cycle();
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    // single read from master 0
    req[0]  = 1'b1;
    cmd[0]  = SCR1_MEM_CMD_RD;
    addr[0] = 32'h0000_0010;
    tcm_ack = 1'b1;
    #1;
    check_eq("single_ack", 32'(ack_o[0][0]), 32'h1);
    cycle();
    req[0]    = 1'b0;
    tcm_ack   = 1'b0;
    tcm_resp  = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("single_resp", 32'(resp_o[0][0]), 32'(SCR1_MEM_RESP_RDY_OK));
    check_eq("single_rdata", rdata_o[0][0], 32'hCAFE_F00D);
    check_eq("single_m1_resp", 32'(resp_o[0][1]), 32'(SCR1_MEM_RESP_NOTRDY));
    cycle();
    idle_inputs();
    cycle();

    // contention with a one-cycle TCM
    do_reset();
    req[0]   = 1'b1;
    req[1]   = 1'b1;
    addr[0]  = 32'h0000_0100;
    addr[1]  = 32'h0000_0200;
    tcm_ack  = 1'b1;
    tcm_resp = SCR1_MEM_RESP_RDY_OK;
    repeat (6) begin
      tcm_rdata = $urandom;
      cycle();
    end
    check_eq("rr_grant_count", 32'(grants[0].size()), 32'd6);
    check_eq("fp_grant_count", 32'(grants[1].size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grants[0].size()) check_eq($sformatf("rr_order%0d", i), 32'(grants[0][i]), 32'(i % 2));
      if (i < grants[1].size()) check_eq($sformatf("fp_order%0d", i), 32'(grants[1][i]), 32'd0);
    end
    // only master 1 requesting: fixed-priority instance grants it too
    req[0] = 1'b0;
    #1;
    check_eq("fp_m1_alone", 32'(ack_o[1][1]), 32'h1);
    cycle();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK;
    cycle();
    idle_inputs();
    cycle();

    // downstream stall while master 1 requests
    do_reset();
    req[1]  = 1'b1;
    addr[1] = 32'h0000_0044;
    tcm_ack = 1'b0;
    repeat (3) begin
      #1;
      check_eq("stall_ack", 32'(ack_o[0][1]), 32'h0);
      cycle();
    end
    tcm_ack = 1'b1;
    #1;
    check_eq("stall_accept", 32'(ack_o[0][1]), 32'h1);
    cycle();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK;
    cycle();
    idle_inputs();
    cycle();

    // slow response ending in an error
    do_reset();
    req[0]  = 1'b1;
    tcm_ack = 1'b1;
    cycle();
    req[1] = 1'b1;
    repeat (2) begin
      #1;
      check_eq("slow_no_grant", 32'(treq_o[0]), 32'h0);
      cycle();
    end
    tcm_resp  = SCR1_MEM_RESP_RDY_ER;
    tcm_rdata = 32'h0BAD_0BAD;
    #1;
    check_eq("slow_err", 32'(resp_o[0][0]), 32'(SCR1_MEM_RESP_RDY_ER));
    check_eq("slow_regrant", 32'(treq_o[0]), 32'h1);
    cycle();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK;
    cycle();
    idle_inputs();
    cycle();

    // reset while master 1 owns the port
    do_reset();
    req[1]  = 1'b1;
    tcm_ack = 1'b1;
    cycle();
    idle_inputs();
    rst_n     = 1'b0;
    tcm_resp  = SCR1_MEM_RESP_RDY_OK;
    tcm_rdata = 32'h1234_5678;
    #1;
    check_eq("rst_mid_resp", 32'(resp_o[0][1]), 32'(SCR1_MEM_RESP_NOTRDY));
    check_eq("rst_mid_rdata", rdata_o[0][1], 32'h0);
    cycle();
    rst_n = 1'b1;
    cycle();
    req[0]   = 1'b1;
    req[1]   = 1'b1;
    tcm_ack  = 1'b1;
    tcm_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    check_eq("rst_ptr0", 32'(ack_o[0][0]), 32'h1);
    cycle();
    idle_inputs();
    tcm_resp = SCR1_MEM_RESP_RDY_OK;
    cycle();

    // randomized traffic
    do_reset();
    repeat (400) begin
      for (int m = 0; m < 2; m++) begin
        req[m]   = ($urandom_range(0, 3) != 0);
        cmd[m]   = type_scr1_mem_cmd_e'(1'($urandom_range(0, 1)));
        width[m] = type_scr1_mem_width_e'(2'($urandom_range(0, 2)));
        addr[m]  = $urandom;
        wdata[m] = $urandom;
      end
      tcm_ack   = ($urandom_range(0, 3) != 0);
      tcm_rdata = $urandom;
      r = $urandom_range(0, 5);
      if (r < 3)      tcm_resp = SCR1_MEM_RESP_NOTRDY;
      else if (r < 5) tcm_resp = SCR1_MEM_RESP_RDY_OK;
      else            tcm_resp = SCR1_MEM_RESP_RDY_ER;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scr1_tcm_dmem_arb
